// File: rtl/gba_clk_rst_gen.sv
// gba_clk_rst_gen: PLL lock qualification, core reset sequencing and fractional CPU clock enable
module gba_clk_rst_gen #(
  parameter int SYNC_STAGES = 2,
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int RST_HOLD_CYCLES = 16,
  parameter int ACC_WIDTH = 32,
  parameter logic [ACC_WIDTH-1:0] CE_INC = 32'h2AF31DC4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pll_locked,
  output logic       sys_rst,
  output logic       ready,
  output logic       cpu_ce,
  output logic [7:0] lock_loss_count
);
  localparam int SW = $clog2(LOCK_STABLE_CYCLES + 1);
  localparam int HW = $clog2(RST_HOLD_CYCLES + 1);
  localparam logic [SW-1:0] STAB_LAST = SW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(RST_HOLD_CYCLES);
  typedef enum logic [1:0] {S_RESET, S_WAIT_LOCK, S_HOLD, S_RUN} state_t;
  state_t state, state_n;
  logic [SYNC_STAGES-1:0] sync;
  logic [SW-1:0] stab_cnt;
  logic [HW-1:0] hold_cnt;
  logic [ACC_WIDTH-1:0] acc;
  logic locked_s, lost, sys_rst_n, ready_n;
  assign locked_s = sync[SYNC_STAGES-1];
  assign lost = !locked_s && (state == S_HOLD || state == S_RUN);
  always_ff @(posedge clk) begin
    if (rst) state <= S_RESET;
    else state <= state_n;
  end
  always_comb begin
    state_n = state;
    case (state)
      S_RESET:     state_n = S_WAIT_LOCK;
      S_WAIT_LOCK: state_n = (locked_s && stab_cnt == STAB_LAST) ? S_HOLD : S_WAIT_LOCK;
      S_HOLD:      state_n = !locked_s ? S_WAIT_LOCK : (hold_cnt == HOLD_LAST) ? S_RUN : S_HOLD;
      default:     state_n = locked_s ? S_RUN : S_WAIT_LOCK;
    endcase
  end
  always_comb begin
    sys_rst_n = state_n != S_RUN;
    ready_n = state_n == S_RUN;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      sync <= '0;
      stab_cnt <= '0;
      hold_cnt <= '0;
      acc <= '0;
      cpu_ce <= 1'b0;
      sys_rst <= 1'b1;
      ready <= 1'b0;
      lock_loss_count <= '0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], pll_locked};
      stab_cnt <= (state == S_WAIT_LOCK && locked_s) ? stab_cnt + 1'b1 : '0;
      hold_cnt <= (state == S_HOLD && state_n == S_HOLD) ? hold_cnt + 1'b1 : '0;
      {cpu_ce, acc} <= (state == S_RUN && state_n == S_RUN) ? {1'b0, acc} + {1'b0, CE_INC} : '0;
      sys_rst <= sys_rst_n;
      ready <= ready_n;
      lock_loss_count <= (lost && lock_loss_count != 8'hFF) ? lock_loss_count + 8'd1 : lock_loss_count;
    end
  end
endmodule
